// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared riscv32i widths and types
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/dff_en_rst.sv
// rtl/dff_en_rst.sv - enabled word flop with async active-low reset
module dff_en_rst #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - multi-port register file with optional bypass and hardwired x0
module reg_file
  import riscv_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter int               DEPTH     = NUM_REGS,
  parameter int               NUM_RD    = 2,
  parameter bit               BYPASS    = 1'b1,
  parameter bit               ZERO_REG  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]    raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic                    wr_ack
);
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_commit;

  // rst_n gates the commit so a write racing reset neither acks nor bypasses
  assign wr_commit = rst_n && we && in_range(waddr) && !(ZERO_REG && waddr == '0);

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    if (ZERO_REG && e == 0) begin : g_zero
      assign mem[e] = '0;
    end else begin : g_word
      logic en;
      assign en = wr_commit && (waddr == AW'(e));
      dff_en_rst #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_word (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .d    (wdata),
        .q    (mem[e])
      );
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    assign ra = raddr[r*AW +: AW];

    always_comb begin
      rd = '0;
      if (!in_range(ra) || (ZERO_REG && ra == '0)) begin
        rd = '0;
      end else if (BYPASS && wr_commit && ra == waddr) begin
        rd = wdata;
      end else begin
        rd = mem[ra];
      end
    end

    assign rdata[r*WIDTH +: WIDTH] = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_commit;
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed check of reg_file against a reference model
module tb_reg_file;
  localparam logic [31:0] RV_A = 32'hDEADBEEF;
  localparam logic [31:0] RV_B = 32'h13579BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic        ack_a, ack_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [20];

  always #5 clk = ~clk;

  // A: 32 entries, bypass on. B: 20 entries, bypass off.
  reg_file #(.DEPTH(32), .BYPASS(1'b1), .RESET_VAL(RV_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .wr_ack(ack_a)
  );
  reg_file #(.DEPTH(20), .BYPASS(1'b0), .RESET_VAL(RV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .wr_ack(ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit commits(input bit is_b);
    int depth;
    depth = is_b ? 20 : 32;
    return rst_n && we && int'(waddr) < depth && waddr != 5'd0;
  endfunction

  function automatic logic [31:0] ref_rd(input bit is_b, input int addr);
    int depth;
    depth = is_b ? 20 : 32;
    if (addr >= depth || addr == 0) return 32'h0;
    if (!is_b && commits(is_b) && addr == int'(waddr)) return wdata;
    return is_b ? mb[addr] : ma[addr];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) ma[i] = RV_A;
    for (int i = 0; i < 20; i++) mb[i] = RV_B;
  endtask

  task automatic check_reads();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd_a p%0d @%0d", p, raddr[p*5 +: 5]), rdata_a[p*32 +: 32], ref_rd(1'b0, int'(raddr[p*5 +: 5])));
      chk($sformatf("rd_b p%0d @%0d", p, raddr[p*5 +: 5]), rdata_b[p*32 +: 32], ref_rd(1'b1, int'(raddr[p*5 +: 5])));
    end
  endtask

  task automatic tick();
    bit ca, cb;
    ca = commits(1'b0);
    cb = commits(1'b1);
    @(posedge clk);
    if (ca) ma[waddr] = wdata;
    if (cb) mb[waddr] = wdata;
    #1;
    chk("ack_a", {31'b0, ack_a}, {31'b0, ca});
    chk("ack_b", {31'b0, ack_b}, {31'b0, cb});
  endtask

  task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1);
    raddr = {r1, r0};
    #1;
  endtask

  initial begin
    rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("rst ack_a", {31'b0, ack_a}, 32'h0);
    chk("rst ack_b", {31'b0, ack_b}, 32'h0);
    for (int a = 0; a < 32; a += 3) begin
      set_rd(5'(a), 5'(31 - a));
      check_reads();
    end
    tick();
    rst_n = 1'b1;

    // consecutive writes to x5, last wins
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr = {5'd0, 5'd5};
    tick();
    wdata = 32'h0BADF00D;
    tick();
    we = 1'b0;
    tick();
    check_reads();
    chk("x5 final", rdata_a[31:0], 32'h0BADF00D);

    // bypass vs no bypass on port 1
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    tick();
    wdata = 32'hCAFEF00D;
    set_rd(5'd0, 5'd7);
    check_reads();
    chk("byp_a", rdata_a[63:32], 32'hCAFEF00D);
    chk("nobyp_b", rdata_b[63:32], 32'h1);
    tick();
    we = 1'b0;
    set_rd(5'd0, 5'd7);
    chk("after_b", rdata_b[63:32], 32'hCAFEF00D);

    // x0 protection
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0);
    check_reads();
    tick();
    check_reads();

    // reset mid-write
    we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA5555;
    set_rd(5'd3, 5'd3);
    #1;
    rst_n = 1'b0;
    reset_model();
    #1;
    check_reads();
    tick();
    check_reads();
    rst_n = 1'b1;
    wdata = 32'h55;
    tick();
    we = 1'b0;
    set_rd(5'd3, 5'd3);
    check_reads();
    chk("x3 after rst", rdata_a[31:0], 32'h55);

    // out-of-range for the 20-entry instance
    we = 1'b1; waddr = 5'd25; wdata = 32'h600DCAFE;
    tick();
    we = 1'b0;
    set_rd(5'd25, 5'd19);
    check_reads();
    chk("oor_b", rdata_b[31:0], 32'h0);

    for (int n = 0; n < 1000; n++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      raddr[4:0] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr[9:5] = ($urandom_range(0, 3) == 0) ? raddr[4:0] : 5'($urandom_range(0, 31));
      #1;
      check_reads();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
